// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: bus commands, requester identity,
// owner-table entry format and the bus geometry constants.
package mem_bus_arbiter_pkg;

   localparam int XLEN       = 32;
   localparam int TAG_W      = 4;
   localparam int NTAG       = 16;
   localparam int STARVE_LIM = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef enum logic {
      ARB_IC = 1'b0,
      ARB_DC = 1'b1
   } ARB_OWNER_T;

   typedef struct packed {
      logic       valid;
      ARB_OWNER_T owner;
   } MEM_TAG_ENTRY_PACKET;

endpackage

// File: rtl/mem_arb_tag_table.sv
// Owner table for outstanding memory tags. A return lookup is combinational;
// the clear of a returned entry is applied before a same-cycle allocation, so
// a tag can be handed straight back out on the cycle it comes home.
// tag_err is sticky: data on a tag nobody owns, or allocation onto a live tag.
module mem_arb_tag_table
   import mem_bus_arbiter_pkg::*;
#(
   parameter int NTAG_P = NTAG
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             alloc_en,
   input  logic [TAG_W-1:0] alloc_tag,
   input  ARB_OWNER_T       alloc_owner,
   input  logic [TAG_W-1:0] ret_tag,
   output logic             ret_hit,
   output ARB_OWNER_T       ret_owner,
   output logic             tag_err
);

   MEM_TAG_ENTRY_PACKET entries [NTAG_P];

   logic ret_miss;
   logic alloc_clash;

   // Lookup of the returning tag and detection of the two error cases.
   always_comb begin
      ret_hit     = (ret_tag != '0) && entries[ret_tag].valid;
      ret_miss    = (ret_tag != '0) && !entries[ret_tag].valid;
      ret_owner   = entries[ret_tag].owner;
      alloc_clash = alloc_en && entries[alloc_tag].valid &&
                    !(ret_hit && (ret_tag == alloc_tag));
   end

   // Table update: clear on return first, then allocate; sticky error flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NTAG_P; i++) begin
            entries[i] <= '0;
         end
         tag_err <= 1'b0;
      end else begin
         if (ret_hit) begin
            entries[ret_tag].valid <= 1'b0;
         end
         if (alloc_en) begin
            entries[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
         end
         if (ret_miss || alloc_clash) begin
            tag_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the icache fetch unit (I) and the dcache
// MSHRs (D). D wins by default; I wins once it has lost STARVE_LIM requesting
// cycles in a row. Load tags are recorded in mem_arb_tag_table so returning
// data reaches only its owner.
// Optional build macro: MEM_ARB_STATS_EN adds grant/conflict counters.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int NTAG_P       = NTAG,
   parameter int STARVE_LIM_P = STARVE_LIM
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       ic2arb_command,
   input  logic [XLEN-1:0]  ic2arb_addr,
   input  logic [1:0]       dc2arb_command,
   input  logic [XLEN-1:0]  dc2arb_addr,
   input  logic [63:0]      dc2arb_data,
   output logic [TAG_W-1:0] arb2ic_response,
   output logic [TAG_W-1:0] arb2dc_response,
   output logic [63:0]      arb2ic_data,
   output logic [TAG_W-1:0] arb2ic_tag,
   output logic [63:0]      arb2dc_data,
   output logic [TAG_W-1:0] arb2dc_tag,
   output logic [1:0]       proc2mem_command,
   output logic [XLEN-1:0]  proc2mem_addr,
   output logic [63:0]      proc2mem_data,
   input  logic [TAG_W-1:0] mem2proc_response,
   input  logic [63:0]      mem2proc_data,
   input  logic [TAG_W-1:0] mem2proc_tag,
`ifdef MEM_ARB_STATS_EN
   output logic [31:0]      stat_ic_grants,
   output logic [31:0]      stat_dc_grants,
   output logic [31:0]      stat_conflicts,
`endif
   output logic             tag_err
);

   logic       ic_req, dc_req, ic_forced;
   logic       grant_ic, grant_dc;
   logic [2:0] starve_cnt;
   logic       alloc_en;
   ARB_OWNER_T alloc_owner;
   logic       ret_hit;
   ARB_OWNER_T ret_owner;

   // Request decode and priority: starvation overrides D's default priority.
   always_comb begin
      ic_req    = (ic2arb_command != BUS_NONE);
      dc_req    = (dc2arb_command != BUS_NONE);
      ic_forced = (starve_cnt >= 3'(STARVE_LIM_P));
      grant_ic  = ic_req && (!dc_req || ic_forced);
      grant_dc  = dc_req && !grant_ic;
      alloc_en  = (mem2proc_response != '0) &&
                  ((grant_ic && (ic2arb_command == BUS_LOAD)) ||
                   (grant_dc && (dc2arb_command == BUS_LOAD)));
      alloc_owner = grant_dc ? ARB_DC : ARB_IC;
   end

   // Forward the winner, route the accept tag and the returned line; all quiet in reset.
   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      arb2ic_response  = '0;
      arb2dc_response  = '0;
      arb2ic_data      = '0;
      arb2ic_tag       = '0;
      arb2dc_data      = '0;
      arb2dc_tag       = '0;
      if (!reset) begin
         if (grant_dc) begin
            proc2mem_command = dc2arb_command;
            proc2mem_addr    = dc2arb_addr;
            proc2mem_data    = dc2arb_data;
            arb2dc_response  = mem2proc_response;
         end else if (grant_ic) begin
            proc2mem_command = ic2arb_command;
            proc2mem_addr    = ic2arb_addr;
            arb2ic_response  = mem2proc_response;
         end
         if (ret_hit) begin
            if (ret_owner == ARB_IC) begin
               arb2ic_data = mem2proc_data;
               arb2ic_tag  = mem2proc_tag;
            end else begin
               arb2dc_data = mem2proc_data;
               arb2dc_tag  = mem2proc_tag;
            end
         end
      end
   end

   // Consecutive lost cycles for I, saturating at the forcing threshold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (ic_req && !grant_ic) begin
         if (starve_cnt < 3'(STARVE_LIM_P)) begin
            starve_cnt <= starve_cnt + 3'd1;
         end
      end else begin
         starve_cnt <= '0;
      end
   end

`ifdef MEM_ARB_STATS_EN
   // Accepted grants per requester and cycles where both were asking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_ic_grants <= '0;
         stat_dc_grants <= '0;
         stat_conflicts <= '0;
      end else begin
         if (grant_ic && (mem2proc_response != '0)) begin
            stat_ic_grants <= stat_ic_grants + 32'd1;
         end
         if (grant_dc && (mem2proc_response != '0)) begin
            stat_dc_grants <= stat_dc_grants + 32'd1;
         end
         if (ic_req && dc_req) begin
            stat_conflicts <= stat_conflicts + 32'd1;
         end
      end
   end
`endif

   mem_arb_tag_table #(
      .NTAG_P(NTAG_P)
   ) u_tag_table (
      .clock       (clock),
      .reset       (reset),
      .alloc_en    (alloc_en),
      .alloc_tag   (mem2proc_response),
      .alloc_owner (alloc_owner),
      .ret_tag     (mem2proc_tag),
      .ret_hit     (ret_hit),
      .ret_owner   (ret_owner),
      .tag_err     (tag_err)
   );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change just after the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic             clock;
   logic             reset;
   logic [1:0]       ic2arb_command;
   logic [XLEN-1:0]  ic2arb_addr;
   logic [1:0]       dc2arb_command;
   logic [XLEN-1:0]  dc2arb_addr;
   logic [63:0]      dc2arb_data;
   logic [TAG_W-1:0] arb2ic_response;
   logic [TAG_W-1:0] arb2dc_response;
   logic [63:0]      arb2ic_data;
   logic [TAG_W-1:0] arb2ic_tag;
   logic [63:0]      arb2dc_data;
   logic [TAG_W-1:0] arb2dc_tag;
   logic [1:0]       proc2mem_command;
   logic [XLEN-1:0]  proc2mem_addr;
   logic [63:0]      proc2mem_data;
   logic [TAG_W-1:0] mem2proc_response;
   logic [63:0]      mem2proc_data;
   logic [TAG_W-1:0] mem2proc_tag;
   logic             tag_err;
`ifdef MEM_ARB_STATS_EN
   logic [31:0]      stat_ic_grants;
   logic [31:0]      stat_dc_grants;
   logic [31:0]      stat_conflicts;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   mem_bus_arbiter dut (
      .clock             (clock),
      .reset             (reset),
      .ic2arb_command    (ic2arb_command),
      .ic2arb_addr       (ic2arb_addr),
      .dc2arb_command    (dc2arb_command),
      .dc2arb_addr       (dc2arb_addr),
      .dc2arb_data       (dc2arb_data),
      .arb2ic_response   (arb2ic_response),
      .arb2dc_response   (arb2dc_response),
      .arb2ic_data       (arb2ic_data),
      .arb2ic_tag        (arb2ic_tag),
      .arb2dc_data       (arb2dc_data),
      .arb2dc_tag        (arb2dc_tag),
      .proc2mem_command  (proc2mem_command),
      .proc2mem_addr     (proc2mem_addr),
      .proc2mem_data     (proc2mem_data),
      .mem2proc_response (mem2proc_response),
      .mem2proc_data     (mem2proc_data),
      .mem2proc_tag      (mem2proc_tag),
`ifdef MEM_ARB_STATS_EN
      .stat_ic_grants    (stat_ic_grants),
      .stat_dc_grants    (stat_dc_grants),
      .stat_conflicts    (stat_conflicts),
`endif
      .tag_err           (tag_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic idle();
      ic2arb_command    = BUS_NONE;
      ic2arb_addr       = '0;
      dc2arb_command    = BUS_NONE;
      dc2arb_addr       = '0;
      dc2arb_data       = '0;
      mem2proc_response = '0;
      mem2proc_data     = '0;
      mem2proc_tag      = '0;
   endtask

   task automatic tick();
      @(negedge clock);
      idle();
   endtask

   initial begin
      // Reset: outputs forced quiet even with live inputs
      reset = 1'b1;
      idle();
      ic2arb_command    = BUS_LOAD;
      ic2arb_addr       = 32'h100;
      mem2proc_response = 4'd3;
      mem2proc_tag      = 4'd3;
      mem2proc_data     = 64'h99;
      #1;
      check("rst_ic_resp", arb2ic_response, 0);
      check("rst_ic_tag", arb2ic_tag, 0);
      check("rst_cmd", proc2mem_command, BUS_NONE);
      check("rst_addr", proc2mem_addr, 0);
      check("rst_tag_err", tag_err, 0);
      tick();
      reset = 1'b0;

      // 1. I alone loads 0x100, accepted as tag 3, then tag 3 returns
      ic2arb_command    = BUS_LOAD;
      ic2arb_addr       = 32'h100;
      mem2proc_response = 4'd3;
      #1;
      check("t1_ic_resp", arb2ic_response, 3);
      check("t1_dc_resp", arb2dc_response, 0);
      check("t1_cmd", proc2mem_command, BUS_LOAD);
      check("t1_addr", proc2mem_addr, 32'h100);
      check("t1_data", proc2mem_data, 0);
      tick();
      mem2proc_tag  = 4'd3;
      mem2proc_data = 64'hDEAD;
      #1;
      check("t1_ret_ic_tag", arb2ic_tag, 3);
      check("t1_ret_ic_data", arb2ic_data, 64'hDEAD);
      check("t1_ret_dc_tag", arb2dc_tag, 0);
      tick();
      #1;
      check("t1_tag_err", tag_err, 0);

      // 2. Both load together: D takes tag 5, I retries and gets tag 6
      ic2arb_command    = BUS_LOAD;
      ic2arb_addr       = 32'h200;
      dc2arb_command    = BUS_LOAD;
      dc2arb_addr       = 32'h300;
      mem2proc_response = 4'd5;
      #1;
      check("t2_dc_resp", arb2dc_response, 5);
      check("t2_ic_resp", arb2ic_response, 0);
      check("t2_addr", proc2mem_addr, 32'h300);
      tick();
      ic2arb_command    = BUS_LOAD;
      ic2arb_addr       = 32'h200;
      mem2proc_response = 4'd6;
      #1;
      check("t2_starve_one", dut.starve_cnt, 1);
      check("t2_retry_resp", arb2ic_response, 6);
      check("t2_retry_addr", proc2mem_addr, 32'h200);
      tick();
      mem2proc_tag  = 4'd5;
      mem2proc_data = 64'h55;
      #1;
      check("t2_starve_zero", dut.starve_cnt, 0);
      check("t2_ret_dc_tag", arb2dc_tag, 5);
      check("t2_ret_dc_data", arb2dc_data, 64'h55);
      check("t2_ret_ic_tag", arb2ic_tag, 0);
      tick();
      mem2proc_tag  = 4'd6;
      mem2proc_data = 64'h66;
      #1;
      check("t2_ret6_ic_tag", arb2ic_tag, 6);
      check("t2_ret6_dc_tag", arb2dc_tag, 0);
      tick();

      // 3. D requests continuously; I wins on its 5th requesting cycle
      for (int i = 1; i <= 5; i++) begin
         ic2arb_command = BUS_LOAD;
         ic2arb_addr    = 32'h400;
         dc2arb_command = BUS_LOAD;
         dc2arb_addr    = 32'h500;
         #1;
         check("t3_starve", dut.starve_cnt, i - 1);
         check("t3_addr", proc2mem_addr, (i < 5) ? 32'h500 : 32'h400);
         tick();
      end
      #1;
      check("t3_starve_clr", dut.starve_cnt, 0);
      check("t3_tag_err", tag_err, 0);

      // 4. D store accepted as tag 7 allocates nothing; tag 7 return is an error
      dc2arb_command    = BUS_STORE;
      dc2arb_addr       = 32'h600;
      dc2arb_data       = 64'h1234_5678;
      mem2proc_response = 4'd7;
      #1;
      check("t4_dc_resp", arb2dc_response, 7);
      check("t4_cmd", proc2mem_command, BUS_STORE);
      check("t4_data", proc2mem_data, 64'h1234_5678);
      tick();
      mem2proc_tag  = 4'd7;
      mem2proc_data = 64'h77;
      #1;
      check("t4_ic_tag", arb2ic_tag, 0);
      check("t4_dc_tag", arb2dc_tag, 0);
      check("t4_dc_data", arb2dc_data, 0);
      tick();
      #1;
      check("t4_tag_err", tag_err, 1);

      // 5. Tag 2 returns for D while I is allocated tag 2
      dc2arb_command    = BUS_LOAD;
      dc2arb_addr       = 32'h700;
      mem2proc_response = 4'd2;
      #1;
      check("t5_dc_resp", arb2dc_response, 2);
      tick();
      ic2arb_command    = BUS_LOAD;
      ic2arb_addr       = 32'h800;
      mem2proc_response = 4'd2;
      mem2proc_tag      = 4'd2;
      mem2proc_data     = 64'hAAAA;
      #1;
      check("t5_ic_resp", arb2ic_response, 2);
      check("t5_dc_tag", arb2dc_tag, 2);
      check("t5_dc_data", arb2dc_data, 64'hAAAA);
      check("t5_ic_tag", arb2ic_tag, 0);
      tick();
      mem2proc_tag  = 4'd2;
      mem2proc_data = 64'hBBBB;
      #1;
      check("t5_ic_tag2", arb2ic_tag, 2);
      check("t5_ic_data2", arb2ic_data, 64'hBBBB);
      check("t5_dc_tag2", arb2dc_tag, 0);
      tick();

      // 6. Three tags outstanding, reset, then the stale returns are dropped
      ic2arb_command    = BUS_LOAD;
      mem2proc_response = 4'd1;
      tick();
      dc2arb_command    = BUS_LOAD;
      mem2proc_response = 4'd3;
      tick();
      ic2arb_command    = BUS_LOAD;
      mem2proc_response = 4'd4;
      tick();
      reset         = 1'b1;
      mem2proc_tag  = 4'd1;
      mem2proc_data = 64'h11;
      #1;
      check("t6_rst_ic_tag", arb2ic_tag, 0);
      check("t6_rst_ic_data", arb2ic_data, 0);
      check("t6_rst_tag_err", tag_err, 0);
      tick();
      reset = 1'b0;
      #1;
      check("t6_tag_err_clr", tag_err, 0);
`ifdef MEM_ARB_STATS_EN
      check("t6_stat_ic", stat_ic_grants, 0);
      check("t6_stat_dc", stat_dc_grants, 0);
      check("t6_stat_conf", stat_conflicts, 0);
`endif
      mem2proc_tag  = 4'd1;
      mem2proc_data = 64'h11;
      #1;
      check("t6_drop1_ic", arb2ic_tag, 0);
      tick();
      mem2proc_tag  = 4'd3;
      mem2proc_data = 64'h33;
      #1;
      check("t6_drop3_dc", arb2dc_tag, 0);
      check("t6_tag_err_set", tag_err, 1);
      tick();
      mem2proc_tag  = 4'd4;
      #1;
      check("t6_drop4_ic", arb2ic_tag, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
